// File: rtl/stage_id.sv
// stage_id: instruction-decode stage of a 5-stage MIPS-style pipeline.
// Holds the IF/ID register, the 32x32 register file (with WB bypass), the
// decoder, hazard detection (load-use and branch/jr operand hazards), branch
// and jump resolution, and the ID/EX pipeline register.
// Ports:
//   clk, rst                               clock, synchronous active-high reset
//   Instr_IF, pc4_IF                       fetched instruction and its PC+4
//   stall                                  hold PC and IF/ID (combinational)
//   PcSrc, Address_ID                      redirect select and target (combinational)
//   RegWrite_WB, WriteReg_WB, WriteData_WB register-file write port
//   MemRead_MEM, WriteReg_MEM              load currently in MEM
//   *_EX                                   registered ID/EX outputs
module stage_id (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Instr_IF,
  input  logic [31:0] pc4_IF,
  output logic        stall,
  output logic [1:0]  PcSrc,
  output logic [31:0] Address_ID,
  input  logic        RegWrite_WB,
  input  logic [4:0]  WriteReg_WB,
  input  logic [31:0] WriteData_WB,
  input  logic        MemRead_MEM,
  input  logic [4:0]  WriteReg_MEM,
  output logic [31:0] pc4_EX,
  output logic [31:0] A_EX,
  output logic [31:0] B_EX,
  output logic [31:0] Imm_EX,
  output logic [31:0] Instr_EX,
  output logic [4:0]  WriteReg_EX,
  output logic        RegWrite_EX,
  output logic        MemRead_EX,
  output logic        MemWrite_EX,
  output logic        MemToReg_EX,
  output logic        ALUSrc_EX,
  output logic        Link_EX
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00, OP_J   = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
    OP_BNE   = 6'h05, OP_ADDI = 6'h08, OP_ORI = 6'h0D, OP_LUI = 6'h0F,
    OP_LW    = 6'h23, OP_SW  = 6'h2B
  } opcode_e;

  // IF/ID
  logic [31:0] ifid_instr_q, ifid_pc4_q;
  logic        ifid_valid_q;
  // Register file
  logic [31:0] rf_q [32];
  // ID/EX
  logic [31:0] pc4_q, a_q, b_q, imm_q, instr_q;
  logic [4:0]  wr_q;
  logic [5:0]  ctrl_q; // {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, Link}

  // Field extraction
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
  assign op    = ifid_instr_q[31:26];
  assign rs    = ifid_instr_q[25:21];
  assign rt    = ifid_instr_q[20:16];
  assign rd    = ifid_instr_q[15:11];
  assign funct = ifid_instr_q[5:0];
  assign imm16 = ifid_instr_q[15:0];

  // Decode; an invalid IF/ID slot or unknown opcode leaves every flag low.
  logic is_r, is_jr, is_lw, is_sw, is_beq, is_bne, is_addi, is_ori, is_lui, is_j, is_jal;
  always_comb begin
    is_r = 1'b0; is_lw = 1'b0; is_sw = 1'b0; is_beq = 1'b0; is_bne = 1'b0;
    is_addi = 1'b0; is_ori = 1'b0; is_lui = 1'b0; is_j = 1'b0; is_jal = 1'b0;
    if (ifid_valid_q) begin
      case (op)
        OP_RTYPE: is_r    = 1'b1;
        OP_LW:    is_lw   = 1'b1;
        OP_SW:    is_sw   = 1'b1;
        OP_BEQ:   is_beq  = 1'b1;
        OP_BNE:   is_bne  = 1'b1;
        OP_ADDI:  is_addi = 1'b1;
        OP_ORI:   is_ori  = 1'b1;
        OP_LUI:   is_lui  = 1'b1;
        OP_J:     is_j    = 1'b1;
        OP_JAL:   is_jal  = 1'b1;
        default:  ;
      endcase
    end
  end
  assign is_jr = is_r && (funct == 6'h08);

  // Control and destination
  logic        reg_write_d;
  logic [4:0]  wr_d;
  logic [5:0]  ctrl_d;
  logic [31:0] imm_d;
  assign reg_write_d = (is_r && !is_jr) || is_lw || is_addi || is_ori || is_lui || is_jal;
  assign wr_d   = !reg_write_d ? 5'd0 : is_jal ? 5'd31 : is_r ? rd : rt;
  assign ctrl_d = {reg_write_d, is_lw, is_sw, is_lw, (is_lw || is_sw || is_addi || is_ori || is_lui), is_jal};
  assign imm_d  = is_ori ? {16'h0000, imm16} : {{16{imm16[15]}}, imm16};

  // Register reads with same-cycle WB bypass; $0 always reads zero.
  logic [31:0] a_d, b_d;
  always_comb begin
    a_d = '0;
    b_d = '0;
    if (rs != 5'd0) a_d = (RegWrite_WB && WriteReg_WB == rs) ? WriteData_WB : rf_q[rs];
    if (rt != 5'd0) b_d = (RegWrite_WB && WriteReg_WB == rt) ? WriteData_WB : rf_q[rt];
  end

  // Hazard detection; a zero source register never matches.
  logic use_rs, use_rt, hz_ex, hz_mem, is_branchy;
  assign use_rs = is_r || is_lw || is_sw || is_beq || is_bne || is_addi || is_ori;
  assign use_rt = (is_r && !is_jr) || is_sw || is_beq || is_bne;
  assign hz_ex  = (use_rs && rs != 5'd0 && rs == wr_q) || (use_rt && rt != 5'd0 && rt == wr_q);
  assign hz_mem = (use_rs && rs != 5'd0 && rs == WriteReg_MEM) ||
                  (use_rt && rt != 5'd0 && rt == WriteReg_MEM);
  assign is_branchy = is_beq || is_bne || is_jr;
  assign stall = (ctrl_q[4] && hz_ex) ||
                 (is_branchy && ((ctrl_q[5] && hz_ex) || (MemRead_MEM && hz_mem)));

  // Redirect resolution; suppressed while stalled.
  logic [31:0] br_target;
  assign br_target = ifid_pc4_q + {{14{imm16[15]}}, imm16, 2'b00};
  always_comb begin
    PcSrc      = 2'd0;
    Address_ID = '0;
    if (!stall) begin
      if ((is_beq && a_d == b_d) || (is_bne && a_d != b_d)) begin
        PcSrc      = 2'd1;
        Address_ID = br_target;
      end else if (is_j || is_jal) begin
        PcSrc      = 2'd2;
        Address_ID = {ifid_pc4_q[31:28], ifid_instr_q[25:0], 2'b00};
      end else if (is_jr) begin
        PcSrc      = 2'd3;
        Address_ID = a_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_instr_q <= '0;
      ifid_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
      pc4_q <= '0; a_q <= '0; b_q <= '0; imm_q <= '0; instr_q <= '0;
      wr_q  <= '0; ctrl_q <= '0;
      for (int unsigned i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      if (RegWrite_WB && WriteReg_WB != 5'd0) rf_q[WriteReg_WB] <= WriteData_WB;
      if (!stall) begin
        ifid_instr_q <= Instr_IF;
        ifid_pc4_q   <= pc4_IF;
        // A taken redirect squashes the just-fetched instruction.
        ifid_valid_q <= (PcSrc == 2'd0);
      end
      pc4_q <= ifid_pc4_q;
      a_q   <= a_d;
      b_q   <= b_d;
      imm_q <= imm_d;
      if (stall) begin
        instr_q <= '0;
        wr_q    <= '0;
        ctrl_q  <= '0;
      end else begin
        instr_q <= ifid_instr_q;
        wr_q    <= wr_d;
        ctrl_q  <= ctrl_d;
      end
    end
  end

  assign pc4_EX      = pc4_q;
  assign A_EX        = a_q;
  assign B_EX        = b_q;
  assign Imm_EX      = imm_q;
  assign Instr_EX    = instr_q;
  assign WriteReg_EX = wr_q;
  assign {RegWrite_EX, MemRead_EX, MemWrite_EX, MemToReg_EX, ALUSrc_EX, Link_EX} = ctrl_q;

endmodule

// File: tb/tb_stage_id.sv
// Directed testbench for stage_id: each task drives one scenario and checks
// the DUT against hand-computed values.
module tb_stage_id;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Instr_IF, pc4_IF;
  logic        stall;
  logic [1:0]  PcSrc;
  logic [31:0] Address_ID;
  logic        RegWrite_WB;
  logic [4:0]  WriteReg_WB;
  logic [31:0] WriteData_WB;
  logic        MemRead_MEM;
  logic [4:0]  WriteReg_MEM;
  logic [31:0] pc4_EX, A_EX, B_EX, Imm_EX, Instr_EX;
  logic [4:0]  WriteReg_EX;
  logic        RegWrite_EX, MemRead_EX, MemWrite_EX, MemToReg_EX, ALUSrc_EX, Link_EX;

  int total = 0;
  int bad   = 0;

  stage_id dut (
    .clk(clk), .rst(rst), .Instr_IF(Instr_IF), .pc4_IF(pc4_IF),
    .stall(stall), .PcSrc(PcSrc), .Address_ID(Address_ID),
    .RegWrite_WB(RegWrite_WB), .WriteReg_WB(WriteReg_WB), .WriteData_WB(WriteData_WB),
    .MemRead_MEM(MemRead_MEM), .WriteReg_MEM(WriteReg_MEM),
    .pc4_EX(pc4_EX), .A_EX(A_EX), .B_EX(B_EX), .Imm_EX(Imm_EX), .Instr_EX(Instr_EX),
    .WriteReg_EX(WriteReg_EX), .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX),
    .MemWrite_EX(MemWrite_EX), .MemToReg_EX(MemToReg_EX), .ALUSrc_EX(ALUSrc_EX),
    .Link_EX(Link_EX)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nops(input int n);
    Instr_IF = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; Instr_IF = '0; pc4_IF = '0;
    RegWrite_WB = 1'b0; WriteReg_WB = '0; WriteData_WB = '0;
    MemRead_MEM = 1'b0; WriteReg_MEM = '0;
    tick(); tick();
    total++; if ({pc4_EX, A_EX, B_EX, Imm_EX, Instr_EX, WriteReg_EX} !== '0)
      begin bad++; $display("FAIL rst_idex_data got=%h exp=0", {pc4_EX, A_EX, B_EX, Imm_EX, Instr_EX, WriteReg_EX}); end
    total++; if ({RegWrite_EX, MemRead_EX, MemWrite_EX, MemToReg_EX, ALUSrc_EX, Link_EX} !== 6'b0)
      begin bad++; $display("FAIL rst_idex_ctrl got=%b exp=000000", {RegWrite_EX, MemRead_EX, MemWrite_EX, MemToReg_EX, ALUSrc_EX, Link_EX}); end
    total++; if ({stall, PcSrc, Address_ID} !== '0)
      begin bad++; $display("FAIL rst_id_comb got=%h exp=0", {stall, PcSrc, Address_ID}); end
    rst = 1'b0;
  endtask

  task automatic test_regfile();
    RegWrite_WB = 1'b1; WriteReg_WB = 5'd1; WriteData_WB = 32'h1111_1111; tick();
    WriteReg_WB = 5'd4; WriteData_WB = 32'h0000_0044; tick();
    RegWrite_WB = 1'b0;
    Instr_IF = 32'h0024_4820; pc4_IF = 32'h20; tick();     // add $9,$1,$4
    Instr_IF = '0; tick();
    total++; if (A_EX !== 32'h1111_1111) begin bad++; $display("FAIL rf_a got=%h exp=11111111", A_EX); end
    total++; if (B_EX !== 32'h44) begin bad++; $display("FAIL rf_b got=%h exp=00000044", B_EX); end
    total++; if (WriteReg_EX !== 5'd9 || RegWrite_EX !== 1'b1)
      begin bad++; $display("FAIL rf_dest got=%0d/%b exp=9/1", WriteReg_EX, RegWrite_EX); end
    total++; if (pc4_EX !== 32'h20 || Instr_EX !== 32'h0024_4820)
      begin bad++; $display("FAIL rf_copy got=%h/%h exp=20/00244820", pc4_EX, Instr_EX); end
  endtask

  // Back-to-back decode of one instruction per cycle.
  task automatic test_decode();
    logic [31:0] ins [7];
    logic [5:0]  ctl [7];
    logic [4:0]  wr  [7];
    logic [31:0] imm [7];
    ins[0] = 32'h342A_8001; ctl[0] = 6'b100010; wr[0] = 5'd10; imm[0] = 32'h0000_8001; // ori $10,$1,0x8001
    ins[1] = 32'h200B_FFFC; ctl[1] = 6'b100010; wr[1] = 5'd11; imm[1] = 32'hFFFF_FFFC; // addi $11,$0,-4
    ins[2] = 32'hAC24_0008; ctl[2] = 6'b001010; wr[2] = 5'd0;  imm[2] = 32'h0000_0008; // sw $4,8($1)
    ins[3] = 32'h8C8C_FFF8; ctl[3] = 6'b110110; wr[3] = 5'd12; imm[3] = 32'hFFFF_FFF8; // lw $12,-8($4)
    ins[4] = 32'h3C0D_1234; ctl[4] = 6'b100010; wr[4] = 5'd13; imm[4] = 32'h0000_1234; // lui $13,0x1234
    ins[5] = 32'hFC0D_1234; ctl[5] = 6'b000000; wr[5] = 5'd0;  imm[5] = 32'h0000_1234; // undefined op
    ins[6] = 32'h018D_7022; ctl[6] = 6'b100000; wr[6] = 5'd14; imm[6] = 32'h0000_7022; // sub $14,$12,$13
    for (int i = 0; i <= 7; i++) begin
      Instr_IF = (i < 7) ? ins[i] : 32'h0;
      pc4_IF   = 32'h100 + 32'(4 * i);
      tick();
      if (i > 0) begin
        total++; if ({RegWrite_EX, MemRead_EX, MemWrite_EX, MemToReg_EX, ALUSrc_EX, Link_EX} !== ctl[i-1])
          begin bad++; $display("FAIL dec_ctrl[%0d] got=%b exp=%b", i-1, {RegWrite_EX, MemRead_EX, MemWrite_EX, MemToReg_EX, ALUSrc_EX, Link_EX}, ctl[i-1]); end
        total++; if (WriteReg_EX !== wr[i-1])
          begin bad++; $display("FAIL dec_wr[%0d] got=%0d exp=%0d", i-1, WriteReg_EX, wr[i-1]); end
        total++; if (Imm_EX !== imm[i-1])
          begin bad++; $display("FAIL dec_imm[%0d] got=%h exp=%h", i-1, Imm_EX, imm[i-1]); end
        total++; if (Instr_EX !== ins[i-1] || pc4_EX !== 32'h100 + 32'(4 * (i-1)))
          begin bad++; $display("FAIL dec_copy[%0d] got=%h/%h exp=%h", i-1, Instr_EX, pc4_EX, ins[i-1]); end
      end
    end
  endtask

  task automatic test_load_use();
    nops(2);
    Instr_IF = 32'h8C22_0000; pc4_IF = 32'h10; tick();     // lw $2,0($1)
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_pre got=%b exp=0", stall); end
    Instr_IF = 32'h0044_1820; pc4_IF = 32'h14; tick();     // add $3,$2,$4
    total++; if (stall !== 1'b1 || PcSrc !== 2'd0) begin bad++; $display("FAIL lu_stall got=%b/%0d exp=1/0", stall, PcSrc); end
    Instr_IF = '0; pc4_IF = 32'h18; tick();
    total++; if ({RegWrite_EX, MemRead_EX, WriteReg_EX, Instr_EX} !== '0)
      begin bad++; $display("FAIL lu_bubble got=%h exp=0", {RegWrite_EX, MemRead_EX, WriteReg_EX, Instr_EX}); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_one_cycle got=%b exp=0", stall); end
    MemRead_MEM = 1'b1; WriteReg_MEM = 5'd2; #1;          // MEM load does not stall a non-branch
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_mem_nonbranch got=%b exp=0", stall); end
    MemRead_MEM = 1'b0; WriteReg_MEM = '0;
    tick();
    total++; if (Instr_EX !== 32'h0044_1820 || WriteReg_EX !== 5'd3 || RegWrite_EX !== 1'b1 || B_EX !== 32'h44)
      begin bad++; $display("FAIL lu_issue got=%h/%0d/%b/%h exp=00441820/3/1/44", Instr_EX, WriteReg_EX, RegWrite_EX, B_EX); end
  endtask

  task automatic test_branch();
    nops(2);
    Instr_IF = 32'h1021_0003; pc4_IF = 32'h104; tick();    // beq $1,$1,+3
    total++; if (PcSrc !== 2'd1 || Address_ID !== 32'h110 || stall !== 1'b0)
      begin bad++; $display("FAIL beq_taken got=%0d/%h/%b exp=1/110/0", PcSrc, Address_ID, stall); end
    MemRead_MEM = 1'b1; WriteReg_MEM = 5'd1; #1;
    total++; if (stall !== 1'b1 || PcSrc !== 2'd0 || Address_ID !== 32'h0)
      begin bad++; $display("FAIL beq_mem_stall got=%b/%0d/%h exp=1/0/0", stall, PcSrc, Address_ID); end
    MemRead_MEM = 1'b0; WriteReg_MEM = '0; #1;
    Instr_IF = 32'h0044_1820; pc4_IF = 32'h108; tick();    // wrong-path add
    total++; if (PcSrc !== 2'd0 || Address_ID !== 32'h0 || RegWrite_EX !== 1'b0)
      begin bad++; $display("FAIL beq_flush_id got=%0d/%h/%b exp=0/0/0", PcSrc, Address_ID, RegWrite_EX); end
    Instr_IF = 32'h1421_0003; pc4_IF = 32'h120; tick();    // bne $1,$1,+3
    total++; if (RegWrite_EX !== 1'b0 || WriteReg_EX !== 5'd0)
      begin bad++; $display("FAIL beq_flush_ex got=%b/%0d exp=0/0", RegWrite_EX, WriteReg_EX); end
    total++; if (PcSrc !== 2'd0 || Address_ID !== 32'h0)
      begin bad++; $display("FAIL bne_not_taken got=%0d/%h exp=0/0", PcSrc, Address_ID); end
    nops(1);
  endtask

  task automatic test_jump();
    Instr_IF = 32'h0C10_0040; pc4_IF = 32'h200; tick();    // jal 0x0100040
    total++; if (PcSrc !== 2'd2 || Address_ID !== 32'h0040_0100)
      begin bad++; $display("FAIL jal_target got=%0d/%h exp=2/00400100", PcSrc, Address_ID); end
    Instr_IF = 32'h0044_1820; pc4_IF = 32'h204; tick();
    total++; if (WriteReg_EX !== 5'd31 || Link_EX !== 1'b1 || RegWrite_EX !== 1'b1 || pc4_EX !== 32'h200)
      begin bad++; $display("FAIL jal_ex got=%0d/%b/%b/%h exp=31/1/1/200", WriteReg_EX, Link_EX, RegWrite_EX, pc4_EX); end
    total++; if (PcSrc !== 2'd0) begin bad++; $display("FAIL jal_flush got=%0d exp=0", PcSrc); end
    Instr_IF = 32'h0020_0008; pc4_IF = 32'h300; tick();    // jr $1
    total++; if (PcSrc !== 2'd3 || Address_ID !== 32'h1111_1111 || stall !== 1'b0)
      begin bad++; $display("FAIL jr_target got=%0d/%h/%b exp=3/11111111/0", PcSrc, Address_ID, stall); end
    Instr_IF = '0; tick();
    total++; if (RegWrite_EX !== 1'b0 || WriteReg_EX !== 5'd0)
      begin bad++; $display("FAIL jr_nowrite got=%b/%0d exp=0/0", RegWrite_EX, WriteReg_EX); end
    nops(1);
  endtask

  task automatic test_bypass();
    Instr_IF = 32'h00A0_3020; pc4_IF = 32'h400; tick();    // add $6,$5,$0
    RegWrite_WB = 1'b1; WriteReg_WB = 5'd5; WriteData_WB = 32'hDEAD_BEEF;
    Instr_IF = 32'h0000_4020; tick();                      // add $8,$0,$0
    total++; if (A_EX !== 32'hDEAD_BEEF || B_EX !== 32'h0)
      begin bad++; $display("FAIL wb_bypass got=%h/%h exp=deadbeef/0", A_EX, B_EX); end
    WriteReg_WB = 5'd0; WriteData_WB = 32'h0000_1234;      // write to $0 is ignored
    Instr_IF = 32'h00A0_3020; tick();
    total++; if (A_EX !== 32'h0 || B_EX !== 32'h0)
      begin bad++; $display("FAIL zero_read got=%h/%h exp=0/0", A_EX, B_EX); end
    RegWrite_WB = 1'b0; Instr_IF = '0; tick();
    total++; if (A_EX !== 32'hDEAD_BEEF)
      begin bad++; $display("FAIL wb_stored got=%h exp=deadbeef", A_EX); end
  endtask

  task automatic test_branch_dep();
    nops(2);
    Instr_IF = 32'h2007_0001; pc4_IF = 32'h3C; tick();     // addi $7,$0,1
    Instr_IF = 32'h14E0_0002; pc4_IF = 32'h40; tick();     // bne $7,$0,+2
    total++; if (stall !== 1'b1 || PcSrc !== 2'd0 || Address_ID !== 32'h0)
      begin bad++; $display("FAIL bdep_stall got=%b/%0d/%h exp=1/0/0", stall, PcSrc, Address_ID); end
    Instr_IF = 32'h0044_1820; pc4_IF = 32'h44; tick();
    total++; if (RegWrite_EX !== 1'b0 || Instr_EX !== 32'h0)
      begin bad++; $display("FAIL bdep_bubble got=%b/%h exp=0/0", RegWrite_EX, Instr_EX); end
    RegWrite_WB = 1'b1; WriteReg_WB = 5'd7; WriteData_WB = 32'h1; #1;
    total++; if (stall !== 1'b0 || PcSrc !== 2'd1 || Address_ID !== 32'h48)
      begin bad++; $display("FAIL bdep_taken got=%b/%0d/%h exp=0/1/48", stall, PcSrc, Address_ID); end
    tick();
    RegWrite_WB = 1'b0;
    nops(2);
    Instr_IF = 32'h2000_0005; pc4_IF = 32'h7C; tick();     // addi $0,$0,5
    Instr_IF = 32'h1000_0001; pc4_IF = 32'h80; tick();     // beq $0,$0,+1
    total++; if (RegWrite_EX !== 1'b1 || WriteReg_EX !== 5'd0)
      begin bad++; $display("FAIL zdst_ex got=%b/%0d exp=1/0", RegWrite_EX, WriteReg_EX); end
    total++; if (stall !== 1'b0 || PcSrc !== 2'd1 || Address_ID !== 32'h84)
      begin bad++; $display("FAIL zdst_nostall got=%b/%0d/%h exp=0/1/84", stall, PcSrc, Address_ID); end
    nops(2);
  endtask

  task automatic test_reset_mid_stall();
    Instr_IF = 32'h8C22_0000; pc4_IF = 32'h500; tick();    // lw $2,0($1)
    Instr_IF = 32'h0044_1820; pc4_IF = 32'h504; tick();    // add $3,$2,$4
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL rms_stall got=%b exp=1", stall); end
    rst = 1'b1; Instr_IF = '0; tick();
    total++; if ({stall, PcSrc, Address_ID} !== '0)
      begin bad++; $display("FAIL rms_comb got=%h exp=0", {stall, PcSrc, Address_ID}); end
    total++; if ({pc4_EX, A_EX, B_EX, Imm_EX, Instr_EX, WriteReg_EX, RegWrite_EX, MemRead_EX, MemWrite_EX, MemToReg_EX, ALUSrc_EX, Link_EX} !== '0)
      begin bad++; $display("FAIL rms_idex got=%h exp=0", {pc4_EX, A_EX, B_EX, Imm_EX, Instr_EX, WriteReg_EX, RegWrite_EX, MemRead_EX, MemWrite_EX, MemToReg_EX, ALUSrc_EX, Link_EX}); end
    rst = 1'b0;
    Instr_IF = 32'h0024_4820; pc4_IF = 32'h20; tick();     // add $9,$1,$4
    total++; if (RegWrite_EX !== 1'b0 || Instr_EX !== 32'h0 || WriteReg_EX !== 5'd0)
      begin bad++; $display("FAIL rms_ifid_invalid got=%b/%h/%0d exp=0/0/0", RegWrite_EX, Instr_EX, WriteReg_EX); end
    Instr_IF = '0; tick();
    total++; if (A_EX !== 32'h0 || B_EX !== 32'h0 || Instr_EX !== 32'h0024_4820)
      begin bad++; $display("FAIL rms_rf_cleared got=%h/%h/%h exp=0/0/00244820", A_EX, B_EX, Instr_EX); end
  endtask

  initial begin
    test_reset();
    test_regfile();
    test_decode();
    test_load_use();
    test_branch();
    test_jump();
    test_bypass();
    test_branch_dep();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
